// File: rtl/iotest_sequencer_if.sv
// iotest_sequencer_if: harness, result and DUT-pin bundle for the I/O test sequencer
interface iotest_sequencer_if;
    logic start, abort, dut_reset, busy, done, pass;
    logic [11:0] pat_out, dut_out, err_mask;
    logic [15:0] err_count, first_err;
    modport master (
        output start, abort, dut_out,
        input dut_reset, pat_out, busy, done, pass, err_mask, err_count, first_err
    );
    modport slave (
        input start, abort, dut_out,
        output dut_reset, pat_out, busy, done, pass, err_mask, err_count, first_err
    );
endinterface

// File: rtl/iotest_sequencer.sv
// iotest_sequencer: drives LFSR patterns into the 12-pin I/O datapath and checks its outputs against a model
module iotest_sequencer #(
    parameter int NUM_PATTERNS = 64,
    parameter int LAT = 0,
    parameter logic [11:0] SEED = 12'hACE
) (
    input logic clock,
    input logic reset,
    iotest_sequencer_if.slave io
);
    localparam logic [2:0] S_IDLE = 3'd0, S_RST = 3'd1, S_RUN = 3'd2, S_DRAIN = 3'd3, S_DONE = 3'd4;
    localparam int D = LAT > 0 ? LAT : 1;
    localparam int EW = 12 * D;
    localparam int KW = 16 * D;
    localparam logic [11:0][11:0] MASKS = {
        12'h0F0, 12'hF00, 12'h03F, 12'hFC0, 12'h0F0, 12'hF0F,
        12'h333, 12'hCCC, 12'h555, 12'hAAA, 12'hFFF, 12'h000
    };
    logic [2:0] state_q, state_d;
    logic [11:0] lfsr_q, lfsr_d;
    logic [15:0] k_q, k_d;
    logic [3:0] idx_q, idx_d;
    logic [1:0] cnt_q, cnt_d;
    logic [11:0] err_mask_q, err_mask_d;
    logic [15:0] err_count_q, err_count_d, first_err_q, first_err_d;
    logic [D-1:0] vld_q, vld_d;
    logic [D-1:0][11:0] exp_q, exp_d;
    logic [D-1:0][15:0] kd_q, kd_d;
    logic [11:0] exp_now, cmp_exp;
    logic [15:0] cmp_k;
    logic run, last, cmp_vld, miss;
    always_comb begin
        exp_now = '0;
        for (int i = 0; i < 12; i++) exp_now[i] = (idx_q == 4'(i + 1)) ^ (^(lfsr_q & MASKS[i]));
    end
    assign run = state_q == S_RUN;
    assign last = k_q == 16'(NUM_PATTERNS - 1);
    assign cmp_vld = LAT == 0 ? run : vld_q[D-1];
    assign cmp_exp = LAT == 0 ? exp_now : exp_q[D-1];
    assign cmp_k = LAT == 0 ? k_q : kd_q[D-1];
    assign miss = cmp_vld && !io.abort && io.dut_out != cmp_exp;
    always_comb begin
        state_d = state_q;
        lfsr_d = lfsr_q;
        k_d = k_q;
        idx_d = idx_q == 4'd11 ? 4'd0 : idx_q + 4'd1;
        cnt_d = cnt_q + 2'd1;
        err_mask_d = miss ? err_mask_q | (io.dut_out ^ cmp_exp) : err_mask_q;
        err_count_d = miss && err_count_q != 16'hFFFF ? err_count_q + 16'd1 : err_count_q;
        first_err_d = miss && first_err_q == 16'hFFFF ? cmp_k : first_err_q;
        vld_d = io.abort ? '0 : D'({vld_q, run});
        exp_d = EW'({exp_q, exp_now});
        kd_d = KW'({kd_q, k_q});
        if (io.abort) begin
            state_d = S_IDLE;
        end else if (io.start && (state_q == S_IDLE || state_q == S_DONE)) begin
            state_d = S_RST;
            lfsr_d = SEED;
            k_d = 16'd0;
            err_mask_d = '0;
            err_count_d = '0;
            first_err_d = 16'hFFFF;
        end else if (state_q == S_RST) begin
            state_d = S_RUN;
            idx_d = 4'd0;
        end else if (run) begin
            // the last pattern stays in the LFSR so DRAIN can keep driving it
            lfsr_d = last ? lfsr_q : {lfsr_q[10:0], ^(lfsr_q & 12'h829)};
            k_d = k_q + 16'd1;
            cnt_d = 2'd0;
            state_d = last ? (LAT > 0 ? S_DRAIN : S_DONE) : S_RUN;
        end else if (state_q == S_DRAIN && cnt_q == 2'(LAT - 1)) begin
            state_d = S_DONE;
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            lfsr_q <= SEED;
            k_q <= '0;
            idx_q <= '0;
            cnt_q <= '0;
            err_mask_q <= '0;
            err_count_q <= '0;
            first_err_q <= 16'hFFFF;
            vld_q <= '0;
            exp_q <= '0;
            kd_q <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q <= lfsr_d;
            k_q <= k_d;
            idx_q <= idx_d;
            cnt_q <= cnt_d;
            err_mask_q <= err_mask_d;
            err_count_q <= err_count_d;
            first_err_q <= first_err_d;
            vld_q <= vld_d;
            exp_q <= exp_d;
            kd_q <= kd_d;
        end
    end
    assign io.dut_reset = state_q == S_RST;
    assign io.pat_out = (run || state_q == S_DRAIN) ? lfsr_q : '0;
    assign io.busy = state_q == S_RST || run || state_q == S_DRAIN;
    assign io.done = state_q == S_DONE;
    assign io.pass = state_q == S_DONE && err_count_q == 16'd0;
    assign io.err_mask = err_mask_q;
    assign io.err_count = err_count_q;
    assign io.first_err = first_err_q;
endmodule

// File: tb/tb_iotest_sequencer.sv
// tb_iotest_sequencer: directed checks of the sequencer against ideal, faulty and pipelined DUT models
module tb_iotest_sequencer;
    localparam logic [11:0] SEED = 12'hACE;
    localparam logic [11:0] MK [12] = '{12'h000, 12'hFFF, 12'hAAA, 12'h555, 12'hCCC, 12'h333,
                                        12'hF0F, 12'h0F0, 12'hFC0, 12'h03F, 12'hF00, 12'h0F0};
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] st = '0;
    logic [4:0] ab = '0;
    logic w_dr [5];
    logic w_busy [5];
    logic w_done [5];
    logic w_pass [5];
    logic [11:0] w_pat [5];
    logic [11:0] w_mask [5];
    logic [15:0] w_cnt [5];
    logic [15:0] w_fe [5];
    int checks = 0;
    int errs = 0;
    always #5 clk = ~clk;
    function automatic logic [11:0] model(input logic [3:0] idx, input logic [11:0] pat);
        logic [11:0] r;
        for (int i = 0; i < 12; i++) r[i] = (idx == 4'(i + 1)) ^ (^(pat & MK[i]));
        return r;
    endfunction
    iotest_sequencer_if bus [5] ();
    iotest_sequencer #(.NUM_PATTERNS(16), .LAT(0), .SEED(SEED)) u_a (.clock(clk), .reset(rst), .io(bus[0]));
    iotest_sequencer #(.NUM_PATTERNS(64), .LAT(0), .SEED(SEED)) u_b (.clock(clk), .reset(rst), .io(bus[1]));
    iotest_sequencer #(.NUM_PATTERNS(16), .LAT(2), .SEED(SEED)) u_c (.clock(clk), .reset(rst), .io(bus[2]));
    iotest_sequencer #(.NUM_PATTERNS(16), .LAT(0), .SEED(SEED)) u_d (.clock(clk), .reset(rst), .io(bus[3]));
    iotest_sequencer #(.NUM_PATTERNS(16), .LAT(0), .SEED(SEED)) u_e (.clock(clk), .reset(rst), .io(bus[4]));
    // 0: ideal, 1: pin 3 stuck low, 2/3: two output registers, 4: pins 1 and 2 swapped
    for (genvar g = 0; g < 5; g++) begin : g_io
        logic [3:0] ix = 4'd0;
        logic [11:0] m;
        logic [11:0] r1 = 12'd0;
        logic [11:0] r2 = 12'd0;
        assign m = model(ix, bus[g].pat_out);
        always @(posedge clk) begin
            ix <= bus[g].dut_reset ? 4'd0 : (ix == 4'd11 ? 4'd0 : ix + 4'd1);
            r1 <= m;
            r2 <= r1;
        end
        assign bus[g].dut_out = g == 1 ? (m & 12'hFF7) : (g == 2 || g == 3) ? r2 :
                                g == 4 ? {m[11:3], m[1], m[2], m[0]} : m;
        assign bus[g].start = st[g];
        assign bus[g].abort = ab[g];
        assign w_dr[g] = bus[g].dut_reset;
        assign w_busy[g] = bus[g].busy;
        assign w_done[g] = bus[g].done;
        assign w_pass[g] = bus[g].pass;
        assign w_pat[g] = bus[g].pat_out;
        assign w_mask[g] = bus[g].err_mask;
        assign w_cnt[g] = bus[g].err_count;
        assign w_fe[g] = bus[g].first_err;
    end
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic gold(input int np, input int mode, output int cnt, output logic [15:0] first);
        logic [11:0] l = SEED;
        logic [11:0] e;
        cnt = 0;
        first = 16'hFFFF;
        for (int k = 0; k < np; k++) begin
            e = model(4'(k % 12), l);
            if (mode == 0 ? e[3] : (e[1] ^ e[2])) begin
                cnt++;
                if (first == 16'hFFFF) first = 16'(k);
            end
            l = {l[10:0], l[11] ^ l[5] ^ l[3] ^ l[0]};
        end
    endtask
    task automatic run(input int j, input int rp, output int n, output int rc, output int bc,
                       output logic [11:0] q0, output logic [11:0] q1, output logic [11:0] q2);
        st[j] = 1'b1;
        n = 0; rc = 0; bc = 0; q0 = '0; q1 = '0; q2 = '0;
        do begin
            tick();
            n++;
            st[j] = n == rp;
            rc += int'(w_dr[j]);
            bc += int'(w_busy[j]);
            if (n == 2) q0 = w_pat[j];
            if (n == 3) q1 = w_pat[j];
            if (n == 4) q2 = w_pat[j];
        end while (!w_done[j] && n < 200);
        st[j] = 1'b0;
    endtask
    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (w_dr[0] !== 1'b0) begin errs++; $display("FAIL rst_dut_reset got %b want 0", w_dr[0]); end
        checks++; if (w_pat[0] !== 12'h000) begin errs++; $display("FAIL rst_pat_out got %h want 000", w_pat[0]); end
        checks++; if (w_busy[0] !== 1'b0) begin errs++; $display("FAIL rst_busy got %b want 0", w_busy[0]); end
        checks++; if (w_done[0] !== 1'b0) begin errs++; $display("FAIL rst_done got %b want 0", w_done[0]); end
        checks++; if (w_pass[0] !== 1'b0) begin errs++; $display("FAIL rst_pass got %b want 0", w_pass[0]); end
        checks++; if (w_mask[0] !== 12'h000) begin errs++; $display("FAIL rst_err_mask got %h want 000", w_mask[0]); end
        checks++; if (w_cnt[0] !== 16'h0000) begin errs++; $display("FAIL rst_err_count got %h want 0000", w_cnt[0]); end
        checks++; if (w_fe[0] !== 16'hFFFF) begin errs++; $display("FAIL rst_first_err got %h want FFFF", w_fe[0]); end
        rst = 1'b0;
        tick();
    endtask
    task automatic test_basic;
        int n, rc, bc;
        logic [11:0] q0, q1, q2;
        run(0, 0, n, rc, bc, q0, q1, q2);
        checks++; if (n !== 18) begin errs++; $display("FAIL basic_done_latency got %0d want 18", n); end
        checks++; if (rc !== 1) begin errs++; $display("FAIL basic_dut_reset_cycles got %0d want 1", rc); end
        checks++; if (bc !== 17) begin errs++; $display("FAIL basic_busy_cycles got %0d want 17", bc); end
        checks++; if (q0 !== 12'hACE) begin errs++; $display("FAIL basic_pat0 got %h want ACE", q0); end
        checks++; if (q1 !== 12'h59C) begin errs++; $display("FAIL basic_pat1 got %h want 59C", q1); end
        checks++; if (q2 !== 12'hB39) begin errs++; $display("FAIL basic_pat2 got %h want B39", q2); end
        checks++; if (w_pass[0] !== 1'b1) begin errs++; $display("FAIL basic_pass got %b want 1", w_pass[0]); end
        checks++; if (w_cnt[0] !== 16'd0) begin errs++; $display("FAIL basic_err_count got %0d want 0", w_cnt[0]); end
        checks++; if (w_mask[0] !== 12'h000) begin errs++; $display("FAIL basic_err_mask got %h want 000", w_mask[0]); end
        checks++; if (w_fe[0] !== 16'hFFFF) begin errs++; $display("FAIL basic_first_err got %h want FFFF", w_fe[0]); end
    endtask
    task automatic test_stuck_pin;
        int n, rc, bc, gc;
        logic [15:0] gf;
        logic [11:0] q0, q1, q2;
        gold(64, 0, gc, gf);
        run(1, 0, n, rc, bc, q0, q1, q2);
        checks++; if (n !== 66) begin errs++; $display("FAIL stuck_done_latency got %0d want 66", n); end
        checks++; if (w_mask[1] !== 12'h008) begin errs++; $display("FAIL stuck_err_mask got %h want 008", w_mask[1]); end
        checks++; if (w_cnt[1] !== 16'(gc)) begin errs++; $display("FAIL stuck_err_count got %0d want %0d", w_cnt[1], gc); end
        checks++; if (w_fe[1] !== gf) begin errs++; $display("FAIL stuck_first_err got %0d want %0d", w_fe[1], gf); end
        checks++; if (w_pass[1] !== 1'b0) begin errs++; $display("FAIL stuck_pass got %b want 0", w_pass[1]); end
    endtask
    task automatic test_latency;
        int n, rc, bc;
        logic [11:0] q0, q1, q2;
        run(2, 0, n, rc, bc, q0, q1, q2);
        checks++; if (n !== 20) begin errs++; $display("FAIL lat2_done_latency got %0d want 20", n); end
        checks++; if (bc !== 19) begin errs++; $display("FAIL lat2_busy_cycles got %0d want 19", bc); end
        checks++; if (w_pass[2] !== 1'b1) begin errs++; $display("FAIL lat2_pass got %b want 1", w_pass[2]); end
        checks++; if (w_cnt[2] !== 16'd0) begin errs++; $display("FAIL lat2_err_count got %0d want 0", w_cnt[2]); end
        run(3, 0, n, rc, bc, q0, q1, q2);
        checks++; if (n !== 18) begin errs++; $display("FAIL lat0pipe_done_latency got %0d want 18", n); end
        checks++; if (w_pass[3] !== 1'b0) begin errs++; $display("FAIL lat0pipe_pass got %b want 0", w_pass[3]); end
        checks++; if (w_cnt[3] === 16'd0) begin errs++; $display("FAIL lat0pipe_err_count got %0d want >0", w_cnt[3]); end
    endtask
    task automatic test_walk_swap;
        int n, rc, bc, gc;
        logic [15:0] gf;
        logic [11:0] q0, q1, q2;
        gold(16, 1, gc, gf);
        run(4, 0, n, rc, bc, q0, q1, q2);
        checks++; if (w_mask[4] !== 12'h006) begin errs++; $display("FAIL swap_err_mask got %h want 006", w_mask[4]); end
        checks++; if (w_fe[4] !== gf) begin errs++; $display("FAIL swap_first_err got %0d want %0d", w_fe[4], gf); end
        checks++; if (w_cnt[4] !== 16'(gc)) begin errs++; $display("FAIL swap_err_count got %0d want %0d", w_cnt[4], gc); end
        checks++; if (w_pass[4] !== 1'b0) begin errs++; $display("FAIL swap_pass got %b want 0", w_pass[4]); end
    endtask
    task automatic test_abort;
        int n, rc, bc;
        logic [11:0] q0, q1, q2;
        st[0] = 1'b1;
        repeat (7) begin tick(); st[0] = 1'b0; end
        ab[0] = 1'b1;
        tick();
        ab[0] = 1'b0;
        checks++; if (w_busy[0] !== 1'b0) begin errs++; $display("FAIL abort_busy got %b want 0", w_busy[0]); end
        checks++; if (w_pat[0] !== 12'h000) begin errs++; $display("FAIL abort_pat_out got %h want 000", w_pat[0]); end
        checks++; if (w_done[0] !== 1'b0) begin errs++; $display("FAIL abort_done got %b want 0", w_done[0]); end
        checks++; if (w_dr[0] !== 1'b0) begin errs++; $display("FAIL abort_dut_reset got %b want 0", w_dr[0]); end
        checks++; if (w_cnt[0] !== 16'd0) begin errs++; $display("FAIL abort_err_count got %0d want 0", w_cnt[0]); end
        checks++; if (w_fe[0] !== 16'hFFFF) begin errs++; $display("FAIL abort_first_err got %h want FFFF", w_fe[0]); end
        run(0, 0, n, rc, bc, q0, q1, q2);
        checks++; if (n !== 18) begin errs++; $display("FAIL abort_rerun_latency got %0d want 18", n); end
        checks++; if (w_pass[0] !== 1'b1) begin errs++; $display("FAIL abort_rerun_pass got %b want 1", w_pass[0]); end
        st[1] = 1'b1;
        tick();
        st[1] = 1'b0;
        checks++; if (w_dr[1] !== 1'b1) begin errs++; $display("FAIL restart_dut_reset got %b want 1", w_dr[1]); end
        checks++; if (w_cnt[1] !== 16'd0) begin errs++; $display("FAIL restart_clear_count got %0d want 0", w_cnt[1]); end
        checks++; if (w_mask[1] !== 12'h000) begin errs++; $display("FAIL restart_clear_mask got %h want 000", w_mask[1]); end
        checks++; if (w_fe[1] !== 16'hFFFF) begin errs++; $display("FAIL restart_clear_first got %h want FFFF", w_fe[1]); end
        repeat (6) tick();
        ab[1] = 1'b1;
        tick();
        ab[1] = 1'b0;
        checks++; if (w_busy[1] !== 1'b0) begin errs++; $display("FAIL abort1_busy got %b want 0", w_busy[1]); end
        checks++; if (w_pat[1] !== 12'h000) begin errs++; $display("FAIL abort1_pat_out got %h want 000", w_pat[1]); end
        st[1] = 1'b1;
        ab[1] = 1'b1;
        tick();
        st[1] = 1'b0;
        ab[1] = 1'b0;
        checks++; if (w_busy[1] !== 1'b0) begin errs++; $display("FAIL abort_beats_start_busy got %b want 0", w_busy[1]); end
        checks++; if (w_dr[1] !== 1'b0) begin errs++; $display("FAIL abort_beats_start_dut_reset got %b want 0", w_dr[1]); end
    endtask
    task automatic test_back_to_back;
        int n, rc, bc;
        logic [11:0] q0, q1, q2;
        run(0, 5, n, rc, bc, q0, q1, q2);
        checks++; if (n !== 18) begin errs++; $display("FAIL start_in_run_latency got %0d want 18", n); end
        checks++; if (rc !== 1) begin errs++; $display("FAIL start_in_run_resets got %0d want 1", rc); end
        checks++; if (w_pass[0] !== 1'b1) begin errs++; $display("FAIL start_in_run_pass got %b want 1", w_pass[0]); end
        run(0, 0, n, rc, bc, q0, q1, q2);
        checks++; if (n !== 18) begin errs++; $display("FAIL restart_done_latency got %0d want 18", n); end
        checks++; if (q0 !== 12'hACE) begin errs++; $display("FAIL restart_pat0 got %h want ACE", q0); end
        checks++; if (q1 !== 12'h59C) begin errs++; $display("FAIL restart_pat1 got %h want 59C", q1); end
        checks++; if (q2 !== 12'hB39) begin errs++; $display("FAIL restart_pat2 got %h want B39", q2); end
        checks++; if (w_pass[0] !== 1'b1) begin errs++; $display("FAIL restart_pass got %b want 1", w_pass[0]); end
    endtask
    task automatic test_mid_reset;
        st[1] = 1'b1;
        tick();
        st[1] = 1'b0;
        repeat (8) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (w_busy[1] !== 1'b0) begin errs++; $display("FAIL midrst_busy got %b want 0", w_busy[1]); end
        checks++; if (w_dr[1] !== 1'b0) begin errs++; $display("FAIL midrst_dut_reset got %b want 0", w_dr[1]); end
        checks++; if (w_pat[1] !== 12'h000) begin errs++; $display("FAIL midrst_pat_out got %h want 000", w_pat[1]); end
        checks++; if (w_done[1] !== 1'b0) begin errs++; $display("FAIL midrst_done got %b want 0", w_done[1]); end
        checks++; if (w_pass[1] !== 1'b0) begin errs++; $display("FAIL midrst_pass got %b want 0", w_pass[1]); end
        checks++; if (w_mask[1] !== 12'h000) begin errs++; $display("FAIL midrst_err_mask got %h want 000", w_mask[1]); end
        checks++; if (w_cnt[1] !== 16'd0) begin errs++; $display("FAIL midrst_err_count got %0d want 0", w_cnt[1]); end
        checks++; if (w_fe[1] !== 16'hFFFF) begin errs++; $display("FAIL midrst_first_err got %h want FFFF", w_fe[1]); end
    endtask
    initial begin
        test_reset();
        test_basic();
        test_stuck_pin();
        test_latency();
        test_walk_swap();
        test_abort();
        test_back_to_back();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end
endmodule
